// File: rtl/cdc_dev_arbiter.sv
// Multiplexes one CDC byte channel between NUM_DEVS device endpoints using a
// {dev_id[3:0], len[3:0]} frame header in both directions.
module cdc_dev_arbiter #(
    parameter int NUM_DEVS    = 2,
    parameter int MAX_PAYLOAD = 8,
    parameter int IN_GAP      = 16,
    parameter int OUT_TIMEOUT = 4800
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  usb_configured_i,
    input  logic [7:0]            out_data_i,
    input  logic                  out_valid_i,
    output logic                  out_ready_o,
    output logic [7:0]            in_data_o,
    output logic                  in_valid_o,
    input  logic                  in_ready_i,
    output logic [8*NUM_DEVS-1:0] dev_out_data_o,
    output logic [NUM_DEVS-1:0]   dev_out_valid_o,
    input  logic [NUM_DEVS-1:0]   dev_out_ready_i,
    input  logic [8*NUM_DEVS-1:0] dev_in_data_i,
    input  logic [NUM_DEVS-1:0]   dev_in_valid_i,
    output logic [NUM_DEVS-1:0]   dev_in_ready_o,
    output logic                  frame_err_o
);

    localparam int ID_W      = (NUM_DEVS > 1) ? $clog2(NUM_DEVS) : 1;
    localparam int GAP_W     = $clog2(IN_GAP + 1);
    localparam int IDLE_W    = $clog2(OUT_TIMEOUT + 1);
    localparam int BUF_AW    = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int BUF_DEPTH = 1 << BUF_AW;

    localparam logic [ID_W-1:0]   LAST_DEV = ID_W'(NUM_DEVS - 1);
    localparam logic [3:0]        MAXP     = 4'(MAX_PAYLOAD);
    localparam logic [GAP_W-1:0]  GAP_LIM  = GAP_W'(IN_GAP);
    localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(OUT_TIMEOUT - 1);
    localparam logic [4:0]        NDEV5    = 5'(NUM_DEVS);

    typedef enum logic [1:0] {OUT_HDR, OUT_DATA, OUT_DROP} out_st_e;
    typedef enum logic [1:0] {IN_ARB, IN_COLLECT, IN_HDR, IN_SEND} in_st_e;

    // Losing USB configuration behaves exactly like a reset.
    logic flush;
    assign flush = rst_i | ~usb_configured_i;

    out_st_e           out_q, out_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [3:0]        rem_q, rem_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              ferr_q, ferr_d;
    logic              sel_out_ready, out_acc;

    always_comb begin
        out_d           = out_q;
        id_d            = id_q;
        rem_d           = rem_q;
        idle_d          = idle_q;
        ferr_d          = 1'b0;
        out_ready_o     = 1'b0;
        dev_out_valid_o = '0;
        dev_out_data_o  = '0;
        sel_out_ready   = 1'b0;
        out_acc         = 1'b0;
        for (int k = 0; k < NUM_DEVS; k++)
            if (id_q == ID_W'(k)) sel_out_ready = dev_out_ready_i[k];
        if (!flush) begin
            case (out_q)
                OUT_HDR: begin
                    out_ready_o = 1'b1;
                    if (out_valid_i) begin
                        id_d   = ID_W'(out_data_i[7:4]);
                        rem_d  = out_data_i[3:0];
                        idle_d = '0;
                        if (out_data_i[3:0] == 4'd0) begin
                            out_d = OUT_HDR;
                        end else if ({1'b0, out_data_i[7:4]} >= NDEV5) begin
                            out_d  = OUT_DROP;
                            ferr_d = 1'b1;
                        end else begin
                            out_d = OUT_DATA;
                        end
                    end
                end
                OUT_DATA: begin
                    out_ready_o = sel_out_ready;
                    for (int k = 0; k < NUM_DEVS; k++) begin
                        if (id_q == ID_W'(k)) begin
                            dev_out_valid_o[k]       = out_valid_i;
                            dev_out_data_o[k*8 +: 8] = out_data_i;
                        end
                    end
                end
                default: out_ready_o = 1'b1;
            endcase
            // Payload states share byte counting and the stall timeout.
            if (out_q != OUT_HDR) begin
                out_acc = out_valid_i & out_ready_o;
                if (out_acc) begin
                    idle_d = '0;
                    rem_d  = rem_q - 4'd1;
                    if (rem_q == 4'd1) out_d = OUT_HDR;
                end else if (idle_q == IDLE_LIM) begin
                    out_d  = OUT_HDR;
                    ferr_d = 1'b1;
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (flush) begin
            out_q  <= OUT_HDR;
            id_q   <= '0;
            rem_q  <= '0;
            idle_q <= '0;
            ferr_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            id_q   <= id_d;
            rem_q  <= rem_d;
            idle_q <= idle_d;
            ferr_q <= ferr_d;
        end
    end

    assign frame_err_o = ferr_q;

    in_st_e           in_q, in_d;
    logic [ID_W-1:0]  rr_q, rr_d, g_q, g_d, arb_g, g_next;
    logic [3:0]       cnt_q, cnt_d, rd_q, rd_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       buf_q [BUF_DEPTH];
    logic             arb_found, sel_in_valid, col_ready, buf_we;
    logic [7:0]       sel_in_data;
    int               best, off;

    // Lowest rotated distance from rr wins.
    always_comb begin
        arb_found = 1'b0;
        arb_g     = '0;
        best      = NUM_DEVS;
        off       = 0;
        for (int j = 0; j < NUM_DEVS; j++) begin
            off = (j + NUM_DEVS - int'(rr_q)) % NUM_DEVS;
            if (dev_in_valid_i[j] && off < best) begin
                best      = off;
                arb_g     = ID_W'(j);
                arb_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_in_valid = 1'b0;
        sel_in_data  = 8'h00;
        for (int j = 0; j < NUM_DEVS; j++) begin
            if (g_q == ID_W'(j)) begin
                sel_in_valid = dev_in_valid_i[j];
                sel_in_data  = dev_in_data_i[j*8 +: 8];
            end
        end
    end

    assign g_next = (g_q == LAST_DEV) ? '0 : g_q + ID_W'(1);

    always_comb begin
        in_d           = in_q;
        g_d            = g_q;
        rr_d           = rr_q;
        cnt_d          = cnt_q;
        rd_d           = rd_q;
        gap_d          = gap_q;
        in_valid_o     = 1'b0;
        in_data_o      = 8'h00;
        dev_in_ready_o = '0;
        col_ready      = 1'b0;
        buf_we         = 1'b0;
        if (!flush) begin
            case (in_q)
                IN_ARB: begin
                    if (arb_found) begin
                        g_d   = arb_g;
                        in_d  = IN_COLLECT;
                        cnt_d = '0;
                        gap_d = '0;
                    end
                end
                IN_COLLECT: begin
                    col_ready = (cnt_q < MAXP);
                    for (int k = 0; k < NUM_DEVS; k++)
                        if (g_q == ID_W'(k)) dev_in_ready_o[k] = col_ready;
                    if (col_ready && sel_in_valid) begin
                        buf_we = 1'b1;
                        cnt_d  = cnt_q + 4'd1;
                        gap_d  = '0;
                    end else if (cnt_q == MAXP) begin
                        in_d = IN_HDR;
                    end else if (gap_q == GAP_LIM) begin
                        // An empty grant means the device withdrew; move on.
                        if (cnt_q != 4'd0) begin
                            in_d = IN_HDR;
                        end else begin
                            in_d = IN_ARB;
                            rr_d = g_next;
                        end
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                IN_HDR: begin
                    in_valid_o = 1'b1;
                    in_data_o  = {4'(g_q), cnt_q};
                    if (in_ready_i) begin
                        in_d = IN_SEND;
                        rd_d = '0;
                    end
                end
                default: begin
                    in_valid_o = 1'b1;
                    in_data_o  = buf_q[rd_q[BUF_AW-1:0]];
                    if (in_ready_i) begin
                        rd_d = rd_q + 4'd1;
                        if (rd_q == cnt_q - 4'd1) begin
                            in_d  = IN_ARB;
                            rr_d  = g_next;
                            cnt_d = '0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (flush) begin
            in_q  <= IN_ARB;
            rr_q  <= '0;
            g_q   <= '0;
            cnt_q <= '0;
            rd_q  <= '0;
            gap_q <= '0;
        end else begin
            in_q  <= in_d;
            rr_q  <= rr_d;
            g_q   <= g_d;
            cnt_q <= cnt_d;
            rd_q  <= rd_d;
            gap_q <= gap_d;
        end
    end

    // Payload storage needs no reset; cnt defines which entries are live.
    always_ff @(posedge clk_i) begin
        if (buf_we) buf_q[cnt_q[BUF_AW-1:0]] <= sel_in_data;
    end

endmodule
